// File: rtl/aes128_stream_core_if.sv
`default_nettype none
// ============================================================================
// Module      : aes128_stream_core_if
// Description : Key, plaintext and ciphertext valid/ready handshake bundle
//               for aes128_stream_core.
// Revision    : 1.0 - initial release
// ============================================================================
interface aes128_stream_core_if #(
    parameter int DATA_W = 8
);
    logic              key_valid;
    logic              key_ready;
    logic [127:0]      key_in;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              key_loaded;
    logic              busy;

    modport master (
        output key_valid, key_in, in_valid, in_data, out_ready,
        input  key_ready, in_ready, out_valid, out_data, key_loaded, busy
    );

    modport slave (
        input  key_valid, key_in, in_valid, in_data, out_ready,
        output key_ready, in_ready, out_valid, out_data, key_loaded, busy
    );
endinterface
`default_nettype wire

// File: rtl/aes128_stream_core.sv
`default_nettype none
// ============================================================================
// Module      : aes128_stream_core
// Description : Iterative AES-128 encryptor, UNROLL rounds per clock, with
//               DATA_W-wide streaming input/output. Define AES_BLOCK_CNT_EN
//               to add the 32-bit blk_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module aes128_stream_core #(
    parameter int DATA_W = 8,
    parameter int UNROLL = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes128_stream_core_if.slave   bus
`ifdef AES_BLOCK_CNT_EN
    ,
    output logic [31:0]           blk_cnt
`endif
);
    localparam int c_NBEATS = 128 / DATA_W;
    localparam int c_NCYC   = 10 / UNROLL;
    localparam int c_BW     = (c_NBEATS > 1) ? $clog2(c_NBEATS) : 1;
    localparam logic [c_BW-1:0] c_LAST = c_BW'(c_NBEATS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ROUND  = 2'd2,
        UNLOAD = 2'd3
    } state_t;

    state_t          r_state, w_next;
    logic [127:0]    r_key, r_rk, r_blk;
    logic [3:0]      r_round;
    logic [c_BW-1:0] r_beat;
    logic            r_key_loaded;
    logic            w_key_ready, w_in_ready, w_out_valid;
    logic            w_key_fire, w_in_fire, w_out_fire, w_last_cyc;
    logic [127:0]    w_asm, w_st, w_rk;
    logic [3:0]      w_rnd;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x126, x252, v;
        x2   = gmul(x, x);       x3   = gmul(x2, x);
        x6   = gmul(x3, x3);     x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);    x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);   x120 = gmul(x60, x60);
        x126 = gmul(x120, x6);   x252 = gmul(x126, x126);
        v    = gmul(x252, x2);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Byte n sits at bits [127-8n]; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] round_fn(input logic [127:0] st, input logic [127:0] rk,
                                              input logic last);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int n = 0; n < 16; n++) sb[n] = sbox(st[127-8*n -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];   a1 = sr[4*c+1];
            a2 = sr[4*c+2]; a3 = sr[4*c+3];
            res[127-32*c -: 32] = last ? {a0, a1, a2, a3} :
                {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return res ^ rk;
    endfunction

    always_comb begin
        w_st  = r_blk;
        w_rk  = r_rk;
        w_rnd = r_round;
        for (int u = 0; u < UNROLL; u++) begin
            w_rnd = r_round + 4'(u);
            w_rk  = key_next(w_rk, rcon(w_rnd));
            w_st  = round_fn(w_st, w_rk, w_rnd == 4'd10);
        end
    end

    assign w_last_cyc = (r_round + 4'(UNROLL - 1)) == 4'd10;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_key_ready = 1'b0;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_key_ready = 1'b1;
                w_in_ready  = r_key_loaded & ~bus.key_valid;
                if (w_in_ready && bus.in_valid) w_next = (c_NBEATS == 1) ? ROUND : LOAD;
            end
            LOAD: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && r_beat == c_LAST) w_next = ROUND;
            end
            ROUND: begin
                if (w_last_cyc) w_next = UNLOAD;
            end
            UNLOAD: begin
                w_out_valid = 1'b1;
                if (bus.out_ready && r_beat == c_LAST) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_key_fire = w_key_ready & bus.key_valid;
    assign w_in_fire  = w_in_ready  & bus.in_valid;
    assign w_out_fire = w_out_valid & bus.out_ready;
    // Beats shift in at the LSB end so the first beat lands most significant.
    assign w_asm = (r_state == IDLE) ? 128'(bus.in_data)
                                     : ((r_blk << DATA_W) | 128'(bus.in_data));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key        <= '0;
            r_rk         <= '0;
            r_blk        <= '0;
            r_round      <= '0;
            r_beat       <= '0;
            r_key_loaded <= 1'b0;
        end else begin
            if (w_key_fire) begin
                r_key        <= bus.key_in;
                r_key_loaded <= 1'b1;
            end
            if (w_in_fire) begin
                if (r_beat == c_LAST) begin
                    r_blk   <= w_asm ^ r_key;
                    r_rk    <= r_key;
                    r_round <= 4'd1;
                    r_beat  <= '0;
                end else begin
                    r_blk  <= w_asm;
                    r_beat <= r_beat + c_BW'(1);
                end
            end
            if (r_state == ROUND) begin
                r_blk <= w_st;
                r_rk  <= w_rk;
                if (w_last_cyc) begin
                    r_round <= '0;
                    r_beat  <= '0;
                end else begin
                    r_round <= r_round + 4'(UNROLL);
                end
            end
            if (w_out_fire) begin
                r_blk  <= r_blk << DATA_W;
                r_beat <= (r_beat == c_LAST) ? '0 : r_beat + c_BW'(1);
            end
        end
    end

`ifdef AES_BLOCK_CNT_EN
    logic [31:0] r_blk_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              r_blk_cnt <= '0;
        else if (w_key_fire)                     r_blk_cnt <= '0;
        else if (w_out_fire && r_beat == c_LAST) r_blk_cnt <= r_blk_cnt + 32'd1;
    end

    assign blk_cnt = r_blk_cnt;
`endif

    assign bus.key_ready  = w_key_ready;
    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_data   = w_out_valid ? r_blk[127 -: DATA_W] : '0;
    assign bus.key_loaded = r_key_loaded;
    assign bus.busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes128_stream_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes128_stream_core
// Description : Directed FIPS-197 vectors on an 8-bit/1-round and a
//               32-bit/5-round instance of aes128_stream_core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes128_stream_core;
    localparam logic [127:0] c_K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   kr_viol  = 0;

    always #5 clk = ~clk;

    aes128_stream_core_if #(.DATA_W(8))  ifa ();
    aes128_stream_core_if #(.DATA_W(32)) ifb ();

`ifdef AES_BLOCK_CNT_EN
    logic [31:0] blk_cnt_a, blk_cnt_b;
`endif

    aes128_stream_core #(.DATA_W(8), .UNROLL(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
`ifdef AES_BLOCK_CNT_EN
        ,
        .blk_cnt (blk_cnt_a)
`endif
    );

    aes128_stream_core #(.DATA_W(32), .UNROLL(5)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
`ifdef AES_BLOCK_CNT_EN
        ,
        .blk_cnt (blk_cnt_b)
`endif
    );

    always @(negedge clk) if (ifa.busy && ifa.key_ready) kr_viol++;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_key(input logic [127:0] k);
        ifa.key_valid = 1'b1;
        ifa.key_in    = k;
        step();
        ifa.key_valid = 1'b0;
    endtask

    task automatic a_send(input logic [127:0] pt);
        int n;
        for (int k = 0; k < 16; k++) begin
            ifa.in_valid = 1'b1;
            ifa.in_data  = pt[127-8*k -: 8];
            #1;
            n = 0;
            while (!ifa.in_ready && n < 20) begin step(); n++; end
            if (n >= 20) chk("a_in_ready_wait", 128'(ifa.in_ready), 128'(1));
            step();
        end
        ifa.in_valid = 1'b0;
    endtask

    // Edge (counted from the last input handshake) on which the first output beat can transfer.
    task automatic a_wait_out(output int lat);
        int n;
        n = 0;
        while (!ifa.out_valid && n < 40) begin step(); n++; end
        lat = n + 1;
    endtask

    task automatic a_recv(output logic [127:0] ct, input int stall_k,
                          input logic [7:0] stall_exp, output int hold_bad);
        int n;
        hold_bad = 0;
        ct = '0;
        ifa.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            n = 0;
            while (!ifa.out_valid && n < 40) begin step(); n++; end
            if (n >= 40) chk("a_out_valid_wait", 128'(ifa.out_valid), 128'(1));
            if (k == stall_k) begin
                ifa.out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    step();
                    if (!ifa.out_valid || ifa.out_data !== stall_exp) hold_bad++;
                end
                ifa.out_ready = 1'b1;
            end
            ct[127-8*k -: 8] = ifa.out_data;
            step();
        end
        ifa.out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] ct, pv;
        int           lat, hb, bad, n;

        rst_n = 1'b0;
        ifa.key_valid = 1'b0; ifa.key_in = '0; ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b0;
        ifb.key_valid = 1'b0; ifb.key_in = '0; ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // {key_ready, in_ready, out_valid, key_loaded, busy}
        chk("a_reset_ctl", 128'({ifa.key_ready, ifa.in_ready, ifa.out_valid, ifa.key_loaded, ifa.busy}), 128'(5'b10000));
        chk("a_reset_data", 128'(ifa.out_data), 128'(0));
        chk("b_reset_ctl", 128'({ifb.key_ready, ifb.in_ready, ifb.out_valid, ifb.key_loaded, ifb.busy}), 128'(5'b10000));

        // App. B vector, 32-bit beats, five rounds per clock
        ifb.key_valid = 1'b1;
        ifb.key_in    = c_K2;
        step();
        ifb.key_valid = 1'b0;
        chk("b_key_loaded", 128'(ifb.key_loaded), 128'(1));
        pv = c_P2;
        for (int k = 0; k < 4; k++) begin
            ifb.in_valid = 1'b1;
            ifb.in_data  = pv[127-32*k -: 32];
            #1;
            n = 0;
            while (!ifb.in_ready && n < 20) begin step(); n++; end
            if (n >= 20) chk("b_in_ready_wait", 128'(ifb.in_ready), 128'(1));
            step();
        end
        ifb.in_valid = 1'b0;
        n = 0;
        while (!ifb.out_valid && n < 40) begin step(); n++; end
        chk("b_latency", 128'(n + 1), 128'(3));
        pv = c_C2;
        ifb.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("b_ct_beat%0d", k), 128'(ifb.out_data), 128'(pv[127-32*k -: 32]));
            step();
        end
        ifb.out_ready = 1'b0;
        chk("b_done_idle", 128'({ifb.out_valid, ifb.busy}), 128'(0));

        // C.1 vector, byte beats, one round per clock
        a_key(c_K1);
        chk("a_key_loaded", 128'(ifa.key_loaded), 128'(1));
        a_send(c_P1);
        chk("a_busy_round", 128'({ifa.busy, ifa.key_ready, ifa.in_ready}), 128'(3'b100));
        a_wait_out(lat);
        chk("a_latency", 128'(lat), 128'(11));
        chk("a_first_beat", 128'(ifa.out_data), 128'(8'h69));
        a_recv(ct, 99, 8'h00, hb);
        chk("a_ct_first", ct, c_C1);
        chk("a_done_idle", 128'({ifa.out_valid, ifa.busy}), 128'(0));

        // Same key reused; consumer stalls 5 cycles once beats 0..4 have been taken
        a_send(c_P1);
        a_wait_out(lat);
        a_recv(ct, 5, 8'h7b, hb);
        chk("a_ct_reuse_bp", ct, c_C1);
        chk("a_bp_hold_7b", 128'(hb), 128'(0));
        chk("a_key_ready_while_busy", 128'(kr_viol), 128'(0));

        // Key and data offered together: key wins, data taken next cycle
        ifa.key_valid = 1'b1;
        ifa.key_in    = c_K1;
        ifa.in_valid  = 1'b1;
        ifa.in_data   = 8'h00;
        #1;
        chk("sim_in_ready_blocked", 128'({ifa.in_ready, ifa.key_ready}), 128'(2'b01));
        step();
        ifa.key_valid = 1'b0;
        #1;
        chk("sim_in_ready_next", 128'({ifa.in_ready, ifa.busy}), 128'(2'b10));
        a_send(c_P1);
        a_wait_out(lat);
        chk("sim_latency", 128'(lat), 128'(11));
        a_recv(ct, 99, 8'h00, hb);
        chk("sim_ct", ct, c_C1);

        // Reset mid-ROUND aborts and forgets the key
        a_send(c_P1);
        repeat (3) step();
        chk("pre_rst_busy", 128'(ifa.busy), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_abort", 128'({ifa.out_valid, ifa.key_loaded, ifa.busy, ifa.in_ready}), 128'(0));
        step();
        rst_n = 1'b1;
        ifa.in_valid = 1'b1;
        ifa.in_data  = 8'h00;
        bad = 0;
        for (int i = 0; i < 14; i++) begin
            #1;
            if (ifa.in_ready || ifa.out_valid || ifa.busy) bad++;
            step();
        end
        ifa.in_valid = 1'b0;
        chk("rst_no_accept_no_out", 128'(bad), 128'(0));
        chk("rst_key_forgotten", 128'(ifa.key_loaded), 128'(0));
        a_key(c_K1);
        a_send(c_P1);
        a_wait_out(lat);
        a_recv(ct, 99, 8'h00, hb);
        chk("post_rst_ct", ct, c_C1);

`ifdef AES_BLOCK_CNT_EN
        // dut_a: cleared by the post-reset key, then one block; dut_b reset after its block
        chk("a_blk_cnt", 128'(blk_cnt_a), 128'(1));
        chk("b_blk_cnt", 128'(blk_cnt_b), 128'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
